// File: rtl/mag_seq.sv
`timescale 1ns/1ps
// mag_seq: multi-cycle magnitude comparator, one DIGIT-wide slice per cycle,
// most-significant slice first, stopping at the first differing slice.
// Optional two's-complement mode via offset-binary conversion at capture.
//
// Ports:
//   clk, rst        clock; asynchronous active-high reset
//   start           request a compare (accepted only in IDLE)
//   is_signed       1 = two's-complement compare, sampled with start
//   A, B            operands, sampled with start
//   busy            high while comparing
//   done            one-cycle pulse, flags valid in that cycle
//   AgtB/AeqB/AltB  result flags, held until the next accepted start
//   ndig            digits examined for the last result
module mag_seq #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DIGIT = 4
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  start,
    input  logic                                  is_signed,
    input  logic [WIDTH-1:0]                      A,
    input  logic [WIDTH-1:0]                      B,
    output logic                                  busy,
    output logic                                  done,
    output logic                                  AgtB,
    output logic                                  AeqB,
    output logic                                  AltB,
    output logic [$clog2(WIDTH/DIGIT+1)-1:0]      ndig
);

    localparam int unsigned NDIG = WIDTH / DIGIT;
    localparam int unsigned IW   = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam int unsigned NW   = $clog2(NDIG + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMP  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic [NW-1:0]    ndig_d;
    logic             gt_d, eq_d, lt_d;
    logic             busy_d, done_d;
    logic [DIGIT-1:0] sl_a, sl_b;

    // Current digit of each captured operand.
    assign sl_a = DIGIT'(a_q >> (32'(idx_q) * DIGIT));
    assign sl_b = DIGIT'(b_q >> (32'(idx_q) * DIGIT));

    // Next-state and next-output logic.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        idx_d   = idx_q;
        ndig_d  = ndig;
        gt_d    = AgtB;
        eq_d    = AeqB;
        lt_d    = AltB;

        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d = A;
                    b_d = B;
                    // Flipping the sign bit maps two's-complement order onto unsigned order.
                    if (is_signed) begin
                        a_d[WIDTH-1] = ~A[WIDTH-1];
                        b_d[WIDTH-1] = ~B[WIDTH-1];
                    end
                    gt_d    = 1'b0;
                    eq_d    = 1'b0;
                    lt_d    = 1'b0;
                    ndig_d  = '0;
                    idx_d   = IW'(NDIG - 1);
                    state_d = CMP;
                end
            end
            CMP: begin
                ndig_d = ndig + NW'(1);
                if (sl_a > sl_b) begin
                    gt_d    = 1'b1;
                    state_d = DONE;
                end else if (sl_a < sl_b) begin
                    lt_d    = 1'b1;
                    state_d = DONE;
                end else if (idx_q == '0) begin
                    eq_d    = 1'b1;
                    state_d = DONE;
                end else begin
                    idx_d = idx_q - IW'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d == CMP);
        done_d = (state_d == DONE);
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            idx_q   <= IW'(NDIG - 1);
            ndig    <= '0;
            AgtB    <= 1'b0;
            AeqB    <= 1'b0;
            AltB    <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            idx_q   <= idx_d;
            ndig    <= ndig_d;
            AgtB    <= gt_d;
            AeqB    <= eq_d;
            AltB    <= lt_d;
            busy    <= busy_d;
            done    <= done_d;
        end
    end

endmodule

// File: tb/tb_mag_seq.sv
`timescale 1ns/1ps
// Bench for mag_seq: one 16-bit/4-bit-digit instance and one 8-bit/1-bit-digit
// instance, directed cases plus random operands against an arithmetic model.
module tb_mag_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        start16, start8;
    logic        is_signed;
    logic [15:0] A, B;

    logic       busy16, done16, gt16, eq16, lt16;
    logic [2:0] ndig16;
    logic       busy8, done8, gt8, eq8, lt8;
    logic [3:0] ndig8;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mag_seq #(.WIDTH(16), .DIGIT(4)) u16 (
        .clk(clk), .rst(rst), .start(start16), .is_signed(is_signed),
        .A(A), .B(B), .busy(busy16), .done(done16),
        .AgtB(gt16), .AeqB(eq16), .AltB(lt16), .ndig(ndig16)
    );

    mag_seq #(.WIDTH(8), .DIGIT(1)) u8 (
        .clk(clk), .rst(rst), .start(start8), .is_signed(is_signed),
        .A(A[7:0]), .B(B[7:0]), .busy(busy8), .done(done8),
        .AgtB(gt8), .AeqB(eq8), .AltB(lt8), .ndig(ndig8)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: signed/unsigned value compare, and the count of digits scanned
    // from the top until the first differing digit (all of them if equal).
    function automatic void model(input int w, input int d, input logic [15:0] a,
                                  input logic [15:0] b, input bit sgn,
                                  output int rel, output int nd);
        longint av, bv, m, dm;
        m  = (longint'(1) << w) - 1;
        dm = (longint'(1) << d) - 1;
        av = longint'(a) & m;
        bv = longint'(b) & m;
        if (sgn && av >= (longint'(1) << (w - 1))) av = av - (longint'(1) << w);
        if (sgn && bv >= (longint'(1) << (w - 1))) bv = bv - (longint'(1) << w);
        rel = (av > bv) ? 1 : ((av < bv) ? -1 : 0);
        nd  = w / d;
        for (int i = w / d - 1; i >= 0; i--) begin
            if (((longint'(a) >> (i * d)) & dm) != ((longint'(b) >> (i * d)) & dm)) begin
                nd = w / d - i;
                break;
            end
        end
    endfunction

    task automatic outs(input bit s8, output logic bz, output logic dn, output logic g,
                        output logic e, output logic l, output logic [31:0] nd);
        bz = s8 ? busy8 : busy16;
        dn = s8 ? done8 : done16;
        g  = s8 ? gt8 : gt16;
        e  = s8 ? eq8 : eq16;
        l  = s8 ? lt8 : lt16;
        nd = s8 ? 32'(ndig8) : 32'(ndig16);
    endtask

    // One compare with cycle-accurate checks. With disturb set, start is pulsed
    // again at cycle 2 with fresh operands, which must not affect the result.
    task automatic run(input bit s8, input logic [15:0] a, input logic [15:0] b,
                       input bit sgn, input bit disturb);
        int rel, nd, cyc;
        logic bz, dn, g, e, l;
        logic [31:0] n;
        model(s8 ? 8 : 16, s8 ? 1 : 4, a, b, sgn, rel, nd);
        A = a; B = b; is_signed = sgn;
        if (s8) start8 = 1'b1; else start16 = 1'b1;
        tick();
        start8 = 1'b0; start16 = 1'b0;
        cyc = 1;
        forever begin
            outs(s8, bz, dn, g, e, l, n);
            if (dn || cyc > 20) break;
            chk("busy_in_cmp", 32'(bz), 32'd1);
            chk("flags_zero_in_cmp", {29'd0, g, e, l}, 32'd0);
            if (disturb && cyc == 2) begin
                A = 16'($urandom); B = 16'($urandom); is_signed = ~sgn;
                if (s8) start8 = 1'b1; else start16 = 1'b1;
            end
            tick();
            start8 = 1'b0; start16 = 1'b0;
            cyc++;
        end
        chk("done_cycle", 32'(cyc), 32'(nd + 1));
        chk("done_pulse", 32'(dn), 32'd1);
        chk("busy_at_done", 32'(bz), 32'd0);
        chk("flags", {29'd0, g, e, l}, {29'd0, rel == 1, rel == 0, rel == -1});
        chk("ndig", n, 32'(nd));
        for (int k = 0; k < 2; k++) begin
            tick();
            outs(s8, bz, dn, g, e, l, n);
            chk("done_one_cycle", 32'(dn), 32'd0);
            chk("busy_idle", 32'(bz), 32'd0);
            chk("flags_held", {29'd0, g, e, l}, {29'd0, rel == 1, rel == 0, rel == -1});
            chk("ndig_held", n, 32'(nd));
        end
    endtask

    initial begin
        logic [15:0] ra, rb;
        bit rs8;
        rst = 1'b1; start16 = 1'b0; start8 = 1'b0; is_signed = 1'b0;
        A = '0; B = '0;
        #12;
        chk("reset_outs16", {25'd0, busy16, done16, gt16, eq16, lt16, ndig16}, 32'd0);
        chk("reset_outs8", {24'd0, busy8, done8, gt8, eq8, lt8, ndig8}, 32'd0);
        tick();
        rst = 1'b0;
        tick();

        // Directed cases
        run(1'b0, 16'h1234, 16'h1234, 1'b0, 1'b0);
        run(1'b0, 16'h8000, 16'h7FFF, 1'b0, 1'b0);
        run(1'b0, 16'h8000, 16'h7FFF, 1'b1, 1'b0);
        run(1'b0, 16'h12F4, 16'h12F5, 1'b0, 1'b0);
        run(1'b0, 16'hFFFF, 16'h0001, 1'b1, 1'b0);
        run(1'b0, 16'h0000, 16'h0001, 1'b0, 1'b1);
        run(1'b1, 16'h0080, 16'h007F, 1'b1, 1'b0);
        run(1'b1, 16'h0055, 16'h0054, 1'b0, 1'b0);
        run(1'b1, 16'h0080, 16'h0080, 1'b1, 1'b1);

        // Reset in the middle of a compare
        A = 16'hABCD; B = 16'hABCD; is_signed = 1'b0; start16 = 1'b1;
        tick();
        start16 = 1'b0;
        tick();
        rst = 1'b1;
        #1;
        chk("abort_outs", {25'd0, busy16, done16, gt16, eq16, lt16, ndig16}, 32'd0);
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("abort_no_done", 32'(done16), 32'd0);
        end
        rst = 1'b0;
        tick();
        chk("abort_idle", {25'd0, busy16, done16, gt16, eq16, lt16, ndig16}, 32'd0);
        run(1'b0, 16'h4321, 16'h4300, 1'b0, 1'b0);

        // Random compares; operands often share a prefix to exercise deep scans
        for (int t = 0; t < 60; t++) begin
            rs8 = 1'($urandom);
            ra  = 16'($urandom);
            case ($urandom_range(0, 3))
                0: rb = ra;
                1: rb = ra ^ 16'(1 << $urandom_range(0, rs8 ? 7 : 15));
                default: rb = 16'($urandom);
            endcase
            run(rs8, ra, rb, 1'($urandom), 1'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mag_seq.md
# mag_seq

Multi-cycle, parametrised magnitude comparator. It succeeds the single-cycle 16-bit ripple comparator used in the datapath. Operands are compared a digit at a time, most-significant digit first, with early termination on the first differing digit and an optional signed (two's-complement) mode. It sits beside the ALU and is driven by the control FSM through a start/busy/done handshake, so wide compares stay off the critical path.

## Interface
- WIDTH, 16, operand width in bits; must be a multiple of DIGIT.
- DIGIT, 4, bits compared per cycle; NDIG = WIDTH/DIGIT.
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset; asynchronous, active-high.
- start  input  1  request a compare; sampled only in IDLE.
- is_signed  input  1  1 = two's-complement compare, 0 = unsigned; sampled with start.
- A  input  WIDTH  first operand; sampled with start.
- B  input  WIDTH  second operand; sampled with start.
- busy  output  1  high while in CMP.
- done  output  1  one-cycle pulse; result flags are valid in that cycle.
- AgtB  output  1  A > B.
- AeqB  output  1  A == B.
- AltB  output  1  A < B.
- ndig  output  clog2(NDIG+1)  number of digits examined for the last result (1..NDIG).

## Operation
- Reset (async, rst=1): state=IDLE, busy=0, done=0, AgtB=AeqB=AltB=0, ndig=0, digit index=NDIG-1.
- States are IDLE, CMP and DONE.
- IDLE:
  - On start=1, capture A and B into operand registers.
  - If is_signed=1, invert bit WIDTH-1 of both captured operands. This offset-binary form makes the unsigned compare order-correct for signed values.
  - Clear AgtB/AeqB/AltB and ndig to 0, set index=NDIG-1, go to CMP.
- CMP, each cycle: compare captured slices [index*DIGIT +: DIGIT] as unsigned values, and increment ndig.
  - Slice A > slice B: AgtB=1, go to DONE.
  - Slice A < slice B: AltB=1, go to DONE.
  - Slices equal and index==0: AeqB=1, go to DONE.
  - Slices equal and index>0: index decrements, stay in CMP.
- DONE: done=1 for exactly this cycle, then go to IDLE.
- Result flags and ndig hold their values until the next start is accepted.
- Exactly one of AgtB/AeqB/AltB is 1 from the DONE cycle until the next accepted start. All three are 0 after reset and while in CMP.
- start is ignored in CMP and DONE; no queuing.
- Changes on A, B or is_signed after capture have no effect on the compare in flight.
- rst asserted at any point aborts the operation and forces the reset values immediately. No done pulse is produced for the aborted compare.

## Timing
- Cycle 0: start=1 in IDLE, captured at the rising edge.
- Cycles 1..k: CMP, busy=1, where k is the number of digits examined (1 ≤ k ≤ NDIG).
- Cycle k+1: DONE, done=1, busy=0, flags valid, ndig=k.
- Cycle k+2: IDLE; a new start is accepted here at the earliest.
- Latency ranges from 2 cycles (MSB digit differs) to NDIG+1 cycles (equal operands, or difference in the last digit).
- Throughput is one compare per k+2 cycles.
- All outputs are registered; no combinational path from inputs to outputs.

## Test plan
- WIDTH=16, DIGIT=4, unsigned, A=0x1234, B=0x1234 -> AeqB=1, ndig=4, busy for cycles 1–4, done at cycle 5 only.
- Unsigned, A=0x8000, B=0x7FFF -> AgtB=1, ndig=1, done at cycle 2. Same operands with is_signed=1 -> AltB=1, ndig=1.
- Unsigned, A=0x12F4, B=0x12F5 -> AltB=1, ndig=4. Signed, A=0xFFFF (-1), B=0x0001 -> AltB=1, ndig=1.
- Start at cycle 0 with A=0x0000, B=0x0001; pulse start again at cycle 2 with different operands, and change A at cycle 2 -> second start ignored, result AltB=1, ndig=4, done at cycle 5. Flags then stay 0/0/1 through idle cycles.
- Start an equal-operand compare, assert rst at cycle 2 (mid-CMP) -> all outputs 0 in the same cycle, no done pulse. After rst release, a new start completes normally.
- WIDTH=8, DIGIT=1, signed, A=0x80 (-128), B=0x7F (127) -> AltB=1, ndig=1. A=0x55, B=0x54 -> AgtB=1, ndig=8, done at cycle 9.
